// File: rtl/alu_src_pkg.sv
// Shared types and constants for the ALU-source select pipeline.
package alu_src_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int ERR_W = 8;

    // One extra select code beyond the register sources addresses the immediate.
    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Sign/zero extension of an immediate field up to operand width.
module imm_ext #(
    parameter int IMM_WIDTH = 8,
    parameter int WIDTH     = 16
) (
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 imm_sext,
    output logic [WIDTH-1:0]     ext
);

    generate
        if (IMM_WIDTH == WIDTH) begin : g_same
            assign ext = imm;
        end else begin : g_wide
            assign ext = imm_sext ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm}
                                  : {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
        end
    endgenerate

endmodule

// File: rtl/alu_src_sel_pipe.sv
// Operand select (register sources or extended immediate) behind a
// two-entry skid buffer; in_ready is registered so no ready path goes upstream.
module alu_src_sel_pipe
    import alu_src_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_SRC   = 4,
    parameter int IMM_WIDTH = 8,
    parameter int SEL_W     = sel_width(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [IMM_WIDTH-1:0]     imm,
    input  logic                     imm_sext,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_sel_err,
    output logic [ERR_W-1:0]         err_count
);

    state_t           state;
    logic [WIDTH-1:0] imm_full;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             accept;
    logic             emit;

    imm_ext #(
        .IMM_WIDTH (IMM_WIDTH),
        .WIDTH     (WIDTH)
    ) u_imm_ext (
        .imm      (imm),
        .imm_sext (imm_sext),
        .ext      (imm_full)
    );

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(sel) == k) sel_data = src_data[k*WIDTH +: WIDTH];
        end
        if (int'(sel) == NUM_SRC) sel_data = imm_full;
        else if (int'(sel) > NUM_SRC) sel_err = 1'b1;
    end

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            if (accept && sel_err && err_count != '1) err_count <= err_count + 1'b1;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data    <= sel_data;
                        out_sel_err <= sel_err;
                        out_valid   <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        out_data    <= sel_data;
                        out_sel_err <= sel_err;
                    end else if (accept) begin
                        skid_data <= sel_data;
                        skid_err  <= sel_err;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (emit) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        out_data    <= skid_data;
                        out_sel_err <= skid_err;
                        in_ready    <= 1'b1;
                        state       <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_src_sel_pipe.sv
// Bench for alu_src_sel_pipe: directed scenarios plus random traffic against a queue model.
module tb_alu_src_sel_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] src [4];
    logic [63:0] src_data;
    logic [7:0]  imm;
    logic        imm_sext;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sel_err;
    logic [7:0]  err_count;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } xfer_t;

    xfer_t q[$];
    int    m_err;
    int    n_chk;
    int    n_fail;
    logic  last_acc;
    int    pushes;

    assign src_data = {src[3], src[2], src[1], src[0]};

    always #5 clk = ~clk;

    alu_src_sel_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_data    (src_data),
        .imm         (imm),
        .imm_sext    (imm_sext),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel_err (out_sel_err),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected operand from the selection rules: registers, extended immediate, or error.
    function automatic xfer_t ref_sel(input int s, input logic [7:0] im, input logic sx);
        xfer_t r;
        int    v;
        r.err  = 1'b0;
        r.data = 16'h0000;
        if (s < 4) begin
            r.data = src[s];
        end else if (s == 4) begin
            v = int'(im);
            if (sx && v >= 128) v = v - 256;
            r.data = 16'(v);
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 16'(out_valid), 16'(q.size() > 0));
        chk("in_ready", 16'(in_ready), 16'(q.size() < 2));
        chk("err_count", 16'(err_count), 16'(m_err));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_sel_err", 16'(out_sel_err), 16'(q[0].err));
        end
    endtask

    // Called just after a falling edge; drives, checks, and advances one cycle.
    task automatic step(input logic iv, input logic ordy, input int s,
                        input logic [7:0] im, input logic sx);
        logic  acc;
        logic  em;
        xfer_t nx;
        in_valid = iv;
        out_ready = ordy;
        sel = 3'(s);
        imm = im;
        imm_sext = sx;
        #1;
        check_outputs();
        acc = iv && (q.size() < 2);
        em  = ordy && (q.size() > 0);
        nx  = ref_sel(s, im, sx);
        @(posedge clk);
        if (em) void'(q.pop_front());
        if (acc) begin
            q.push_back(nx);
            pushes++;
            if (nx.err && m_err < 255) m_err++;
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", 16'(out_valid), 16'h0000);
        chk("rst_in_ready", 16'(in_ready), 16'h0001);
        chk("rst_err_count", 16'(err_count), 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_sel_err", 16'(out_sel_err), 16'h0000);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            step(1'b0, 1'b1, 0, 8'h00, 1'b0);
            guard++;
        end
        chk("drain_empty", 16'(q.size()), 16'h0000);
    endtask

    initial begin
        int idx;
        int cyc;
        n_chk = 0;
        n_fail = 0;
        m_err = 0;
        pushes = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        imm = 8'h00;
        imm_sext = 1'b0;
        sel = 3'd0;
        for (int k = 0; k < 4; k++) src[k] = 16'h1000 + 16'(k);

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic select sweep at full throughput
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b1, s, 8'h00, 1'b0);
            chk("basic_sel", out_data, 16'h1000 + 16'(s));
        end
        drain();

        // Immediate extension
        step(1'b1, 1'b1, 4, 8'hF6, 1'b1);
        chk("imm_sext", out_data, 16'hFFF6);
        step(1'b1, 1'b1, 4, 8'hF6, 1'b0);
        chk("imm_zext", out_data, 16'h00F6);
        drain();

        // Back-pressure: only two transfers absorbed, then resume in order
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, idx, 8'h00, 1'b0);
            if (last_acc) idx++;
        end
        chk("bp_accepts", 16'(idx), 16'h0002);
        cyc = 0;
        while (idx < 4 && cyc < 10) begin
            step(1'b1, 1'b1, idx, 8'h00, 1'b0);
            if (last_acc) idx++;
            cyc++;
        end
        chk("bp_all_sent", 16'(idx), 16'h0004);
        drain();

        // Illegal select, err_count saturation
        for (int c = 0; c < 300; c++) step(1'b1, 1'b1, 7, 8'h55, 1'b1);
        chk("err_sat", 16'(err_count), 16'h00FF);
        drain();

        // Reset while holding two entries
        step(1'b1, 1'b0, 1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 2, 8'h00, 1'b0);
        chk("two_in_ready", 16'(in_ready), 16'h0000);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 0, 8'h00, 1'b0);

        // Random traffic against the queue model
        pushes = 0;
        cyc = 0;
        while (pushes < 10000 && cyc < 40000) begin
            int s;
            for (int k = 0; k < 4; k++) src[k] = 16'($urandom);
            if ($urandom_range(0, 9) == 0) s = 5 + int'($urandom_range(0, 2));
            else s = int'($urandom_range(0, 4));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 s, 8'($urandom), 1'($urandom));
            cyc++;
        end
        chk("rand_done", 16'(pushes >= 10000), 16'h0001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_src_sel_pipe.md
# alu_src_sel_pipe

Parametrised, pipelined successor to the ALU-source 2:1 mux. Selects one of NUM_SRC register operands or a sign/zero-extended immediate, then registers the result behind a valid/ready handshake with a two-entry skid buffer. Sits between the register-read stage and the ALU operand input, so back-pressure from the ALU never produces a combinational ready path upstream.

## Interface
- WIDTH, 16, operand width in bits.
- NUM_SRC, 4, number of register-operand sources (at least 2).
- IMM_WIDTH, 8, immediate field width (at most WIDTH).
- SEL_W, $clog2(NUM_SRC+1), select width (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a transfer.
- in_ready  out  1  block can accept a transfer.
- src_data  in  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- imm  in  IMM_WIDTH  immediate field.
- imm_sext  in  1  1 = sign-extend imm, 0 = zero-extend imm.
- sel  in  SEL_W  0..NUM_SRC-1 selects a source; NUM_SRC selects the immediate; larger values are illegal.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  selected operand.
- out_sel_err  out  1  qualifies out_data: the transfer used an illegal sel.
- err_count  out  8  saturating count of accepted illegal-sel transfers.

## Operation
- Accept occurs when in_valid and in_ready are both high. Emit occurs when out_valid and out_ready are both high.
- Selection is computed combinationally from inputs sampled at accept time.
  - Register source: out_data = src_data[sel].
  - Immediate: imm extended to WIDTH according to imm_sext.
  - Illegal sel: data = 0 and sel_err = 1.
- Storage: main register (drives outputs) plus skid register. States:
  - EMPTY: accept writes main; next state ONE.
  - ONE: accept with emit writes main and stays ONE. Accept without emit writes skid; next state TWO. Emit without accept goes to EMPTY.
  - TWO: emit moves skid into main; next state ONE. No accept is possible in TWO.
- in_ready is registered and equals "state is not TWO". out_valid is registered and equals "state is not EMPTY".
- Order is strictly FIFO. No transfer is dropped or duplicated.
- err_count increments by 1 on each accepted illegal-sel transfer and saturates at 255. It never wraps.
- Input changes while in_valid is low, or while in_ready is low, have no effect.

## Timing
- Reset values (asynchronous, while rst_n is low):
  - state = EMPTY, out_valid = 0, out_data = 0, out_sel_err = 0.
  - err_count = 0, skid register = 0, in_ready = 1.
  - Inputs are ignored while rst_n is low.
- Latency: a transfer accepted on edge N is visible on out_data/out_valid after edge N. It is consumable on edge N+1 if out_ready is high.
- Throughput: 1 transfer per cycle while out_ready stays high.
- out_ready low for k cycles starting in state ONE: exactly one more transfer is absorbed, then in_ready drops in the cycle after that accept.
- Simultaneous accept and emit in state ONE: the new data replaces main on the same edge. No bubble.
- Reset asserted mid-operation: all buffered transfers are discarded immediately and err_count clears.
- out_data and out_sel_err are stable while out_valid is high and out_ready is low.

## Structure
- Package alu_src_pkg holds:
  - the state enum (EMPTY, ONE, TWO);
  - the err_count width constant (8);
  - a function computing SEL_W from NUM_SRC.
- Sub-module imm_ext (parameters IMM_WIDTH and WIDTH, purely combinational) performs sign/zero extension. The top level instantiates it once.
- The skid logic stays in the top level.

## Test plan
- Basic select: WIDTH=16, NUM_SRC=4, src k = 16'h1000+k, out_ready=1. Sweep sel 0..3 -> out_data 1000,1001,1002,1003 one cycle later; out_sel_err=0.
- Immediate: sel=4, imm=8'hF6. imm_sext=1 -> 16'hFFF6; imm_sext=0 -> 16'h00F6.
- Back-pressure: stream sel=0..3 with out_ready=0 -> 2 accepts, then in_ready=0. Release out_ready -> 1000,1001 emitted in order, then remaining transfers with no loss or duplicate.
- Illegal sel: sel=7 accepted 300 times -> out_data=0 and out_sel_err=1 each time; err_count reaches 255 and holds.
- Reset mid-stream: assert rst_n=0 in state TWO -> out_valid=0, in_ready=1, err_count=0 immediately; no stale data after release.
- Random back-pressure: random in_valid/out_ready, 10k transfers -> output sequence matches the scoreboard exactly.
